// File: rtl/cpu_pkg.sv
// Shared definitions for the single-issue core's sequencing logic.
//   state_t   : sequencer states, also exported on cpu_step_ctrl.state_o
//   pc_sel_t  : next-PC source select driven to the PC mux
//   CS_*      : bit positions inside the decoder's 13-bit control word
//   pc_sel_decode : chooses the next-PC source from the decoded control
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        PCSEL_SEQ  = 2'd0,   // PC + 4
        PCSEL_BR   = 2'd1,   // PC + imm (taken branch, JAL)
        PCSEL_JALR = 2'd2    // rs1 + imm
    } pc_sel_t;

    localparam int CS_W      = 13;
    localparam int CS_RFWE   = 5;
    localparam int CS_STORE  = 7;
    localparam int CS_BRANCH = 9;
    localparam int CS_LOAD   = 10;
    localparam int CS_JAL    = 11;

    // JAL outranks JALR, which outranks a conditional branch.
    function automatic pc_sel_t pc_sel_decode(input logic [CS_W-1:0] cs,
                                              input logic            jalr,
                                              input logic            taken);
        pc_sel_t sel;
        sel = PCSEL_SEQ;
        if (cs[CS_JAL])
            sel = PCSEL_BR;
        else if (jalr)
            sel = PCSEL_JALR;
        else if (cs[CS_BRANCH] && taken)
            sel = PCSEL_BR;
        return sel;
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive wait cycles and flags the one that reaches TIMEOUT.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : the sequencer is waiting on a memory or the multiplier
//   clr        : the sequencer is not waiting (leaving or passing through)
//   timeout    : high on the TIMEOUT-th consecutive wait cycle
module stall_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic timeout
);

    // Counter holds the number of wait cycles already completed, so it only
    // needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    assign timeout = en && (count == CW'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && !timeout)
            count <= count + CW'(1);
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Multi-cycle sequencer for the single-issue RISC-V core.
//   clk, rst_n        : clock, asynchronous active-low reset
//   ctrl_signal[12:0] : decoder control word (see CS_* in cpu_pkg)
//   is_jalr, is_mul   : decoded instruction class flags
//   branch_taken      : ALU compare result, sampled when leaving S_EX
//   mem_stall_I/_D    : instruction / data memory busy
//   mul_ready         : multiplier result valid pulse
//   mem_cen_I/_D, mem_wen_D, ir_we, mul_valid, rf_we, pc_we : strobes
//   pc_sel            : next-PC source, latched when leaving S_EX
//   retired           : completed-instruction count (wraps)
//   err               : sticky watchdog error
//   state_o           : current state for debug
module cpu_step_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CS_W-1:0]  ctrl_signal,
    input  logic             is_jalr,
    input  logic             is_mul,
    input  logic             branch_taken,
    input  logic             mem_stall_I,
    input  logic             mem_stall_D,
    input  logic             mul_ready,
    output logic             mem_cen_I,
    output logic             mem_cen_D,
    output logic             mem_wen_D,
    output logic             ir_we,
    output logic             mul_valid,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [CNT_W-1:0] retired,
    output logic             err,
    output logic [2:0]       state_o
);

    state_t  state, state_nxt;
    pc_sel_t pc_sel_q;
    logic    waiting;
    logic    timeout;
    logic    is_mem_op;

    // ALU op and the other decoder bits are consumed elsewhere in the core.
    logic unused_cs;
    assign unused_cs = &{1'b0, ctrl_signal};

    assign is_mem_op = ctrl_signal[CS_LOAD] || ctrl_signal[CS_STORE];
    assign state_o   = state;
    assign pc_sel    = pc_sel_q;

    // The fetch request is registered, so the IR is loaded on the cycle the
    // outstanding request completes. mem_cen_I is only ever high in S_IF and
    // is cleared by reset and in S_ERR, so ir_we inherits those guarantees.
    assign ir_we = mem_cen_I && !mem_stall_I;

    // Kept apart from the next-state logic: the watchdog's timeout depends
    // on this, and next-state depends on timeout.
    always_comb begin
        waiting = 1'b0;
        unique case (state)
            S_IF:    waiting = !(mem_cen_I && !mem_stall_I);
            S_EX:    waiting = is_mul && !mul_ready;
            S_MEM:   waiting = mem_stall_D;
            default: waiting = 1'b0;
        endcase
    end

    stall_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (waiting),
        .clr     (!waiting),
        .timeout (timeout)
    );

    // NOTE: next_state defaults to the current state before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IF: begin
                if (!waiting)
                    state_nxt = S_ID;
                else if (timeout)
                    state_nxt = S_ERR;
            end
            S_ID: state_nxt = S_EX;
            S_EX: begin
                if (!waiting)
                    state_nxt = is_mem_op ? S_MEM : S_WB;
                else if (timeout)
                    state_nxt = S_ERR;
            end
            S_MEM: begin
                if (!waiting)
                    state_nxt = S_WB;
                else if (timeout)
                    state_nxt = S_ERR;
            end
            S_WB:    state_nxt = S_IF;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IF;
        else
            state <= state_nxt;
    end

    // Strobes are registered from the next state, so each one is high for
    // exactly the cycles spent in its state and is clean at reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cen_I <= 1'b0;
            mem_cen_D <= 1'b0;
            mem_wen_D <= 1'b0;
            mul_valid <= 1'b0;
            rf_we     <= 1'b0;
            pc_we     <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_cen_I <= (state_nxt == S_IF);
            mem_cen_D <= (state_nxt == S_MEM);
            mem_wen_D <= (state_nxt == S_MEM) && ctrl_signal[CS_STORE];
            // Only on the entry cycle of S_EX.
            mul_valid <= (state_nxt == S_EX) && (state != S_EX) && is_mul;
            rf_we     <= (state_nxt == S_WB) && ctrl_signal[CS_RFWE]
                         && !ctrl_signal[CS_STORE];
            pc_we     <= (state_nxt == S_WB);
            err       <= err || (state_nxt == S_ERR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_sel_q <= PCSEL_SEQ;
            retired  <= '0;
        end else begin
            if (state == S_EX && (state_nxt == S_MEM || state_nxt == S_WB))
                pc_sel_q <= pc_sel_decode(ctrl_signal, is_jalr, branch_taken);
            if (state == S_WB)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
module tb_cpu_step_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    localparam logic [12:0] C_ADD  = 13'h0020;
    localparam logic [12:0] C_LW   = 13'h0420;
    localparam logic [12:0] C_SW   = 13'h0080;
    localparam logic [12:0] C_BEQ  = 13'h0208;
    localparam logic [12:0] C_JALR = 13'h0020;
    localparam logic [12:0] C_JAL  = 13'h0820;
    localparam logic [12:0] C_MUL  = 13'h0020;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [12:0]      ctrl_signal;
    logic             is_jalr, is_mul, branch_taken;
    logic             mem_stall_I, mem_stall_D, mul_ready;
    logic             mem_cen_I, mem_cen_D, mem_wen_D, ir_we, mul_valid;
    logic             rf_we, pc_we, err;
    logic [1:0]       pc_sel;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state_o;

    cpu_step_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_signal(ctrl_signal),
        .is_jalr(is_jalr), .is_mul(is_mul), .branch_taken(branch_taken),
        .mem_stall_I(mem_stall_I), .mem_stall_D(mem_stall_D),
        .mul_ready(mul_ready), .mem_cen_I(mem_cen_I), .mem_cen_D(mem_cen_D),
        .mem_wen_D(mem_wen_D), .ir_we(ir_we), .mul_valid(mul_valid),
        .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .retired(retired),
        .err(err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ret  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Observations collected over one instruction.
    int         o_cycles, o_ex, o_mem, o_mulv, o_cend, o_wend, o_irwe, o_bad;
    logic       o_rf_wb, o_pcwe_wb;
    logic [1:0] o_pcsel;
    bit         o_done;

    // Runs one instruction starting in S_IF with a fetch already requested.
    // stall_d: number of S_MEM cycles with the data memory busy.
    // mul_delay: S_EX cycle index (entry = 0) on which mul_ready pulses.
    task automatic run_instr(input logic [12:0] cs, input logic jalr,
                             input logic mul, input logic taken,
                             input int stall_d, input int mul_delay);
        bit seen_wb;
        seen_wb = 0;
        o_cycles = 0; o_ex = 0; o_mem = 0; o_mulv = 0; o_cend = 0;
        o_wend = 0; o_irwe = 0; o_bad = 0; o_rf_wb = 0; o_pcwe_wb = 0;
        o_pcsel = 2'd3; o_done = 0;
        ctrl_signal = cs; is_jalr = jalr; is_mul = mul; branch_taken = taken;
        for (int i = 0; i < 64; i++) begin
            o_cycles++;
            if (mul_valid) o_mulv++;
            if (mem_cen_D) o_cend++;
            if (mem_wen_D) o_wend++;
            if (ir_we)     o_irwe++;
            if (state_o == 3'd4) begin
                o_rf_wb = rf_we; o_pcwe_wb = pc_we; o_pcsel = pc_sel;
                seen_wb = 1;
            end else if (rf_we || pc_we) begin
                o_bad++;
            end
            mul_ready = (state_o == 3'd2) && mul && (o_ex == mul_delay);
            if (state_o == 3'd2) o_ex++;
            // Data-stall is held high outside S_MEM, where it must be ignored.
            mem_stall_D = (state_o != 3'd3) || (o_mem < stall_d);
            if (state_o == 3'd3) o_mem++;
            tick;
            if (seen_wb && state_o == 3'd0) begin
                o_done = 1;
                break;
            end
        end
        mul_ready = 0; mem_stall_D = 0;
    endtask

    task automatic expect_instr(input string tag, input int cycles,
                                input int ex, input int mem, input int mulv,
                                input int wend, input logic rf,
                                input logic [1:0] sel);
        check({tag, ".done"},   32'(o_done), 1);
        check({tag, ".cycles"}, o_cycles, cycles);
        check({tag, ".ex"},     o_ex, ex);
        check({tag, ".mem"},    o_mem, mem);
        check({tag, ".cen_d"},  o_cend, mem);
        check({tag, ".wen_d"},  o_wend, wend);
        check({tag, ".mulv"},   o_mulv, mulv);
        check({tag, ".ir_we"},  o_irwe, 1);
        check({tag, ".rf_we"},  32'(o_rf_wb), 32'(rf));
        check({tag, ".pc_we"},  32'(o_pcwe_wb), 1);
        check({tag, ".pc_sel"}, 32'(o_pcsel), 32'(sel));
        check({tag, ".stray"},  o_bad, 0);
        exp_ret = (exp_ret + 1) % (1 << CNT_W);
        check({tag, ".retired"}, 32'(retired), exp_ret);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".strobes"},
              {25'd0, mem_cen_I, mem_cen_D, mem_wen_D, ir_we, mul_valid,
               rf_we, pc_we}, 0);
    endtask

    initial begin
        int n;
        rst_n = 0; ctrl_signal = '0; is_jalr = 0; is_mul = 0;
        branch_taken = 0; mem_stall_I = 0; mem_stall_D = 0; mul_ready = 0;

        // Reset state
        tick;
        check("rst.state", 32'(state_o), 0);
        check_quiet("rst");
        check("rst.pc_sel", 32'(pc_sel), 0);
        check("rst.retired", 32'(retired), 0);
        check("rst.err", 32'(err), 0);
        rst_n = 1;
        tick;
        check("rel.cen_i", 32'(mem_cen_I), 1);

        run_instr(C_ADD, 0, 0, 0, 0, 0);
        expect_instr("add", 4, 1, 0, 0, 0, 1, 2'd0);
        run_instr(C_LW, 0, 0, 0, 3, 0);
        expect_instr("lw", 8, 1, 4, 0, 0, 1, 2'd0);
        run_instr(C_SW, 0, 0, 0, 0, 0);
        expect_instr("sw", 5, 1, 1, 0, 1, 0, 2'd0);
        run_instr(C_BEQ, 0, 0, 1, 0, 0);
        expect_instr("beq_t", 4, 1, 0, 0, 0, 0, 2'd1);
        run_instr(C_BEQ, 0, 0, 0, 0, 0);
        expect_instr("beq_nt", 4, 1, 0, 0, 0, 0, 2'd0);
        run_instr(C_JALR, 1, 0, 0, 0, 0);
        expect_instr("jalr", 4, 1, 0, 0, 0, 1, 2'd2);
        run_instr(C_JAL, 0, 0, 0, 0, 0);
        expect_instr("jal", 4, 1, 0, 0, 0, 1, 2'd1);
        run_instr(C_MUL, 0, 1, 0, 0, 5);
        expect_instr("mul", 9, 6, 0, 1, 0, 1, 2'd0);
        run_instr(C_MUL, 0, 1, 0, 0, 0);
        expect_instr("mul0", 4, 1, 0, 1, 0, 1, 2'd0);

        // Instruction memory stuck busy: watchdog trips after TIMEOUT cycles
        mem_stall_I = 1; rst_n = 0;
        tick;
        rst_n = 1;
        exp_ret = 0;
        n = 0;
        while (state_o != 3'd7 && n < 32) begin
            tick;
            n++;
        end
        check("wdog.cycles", n, TIMEOUT);
        check("wdog.err", 32'(err), 1);
        check_quiet("wdog");
        mem_stall_I = 0;
        tick; tick; tick;
        check("err.state", 32'(state_o), 7);
        check("err.sticky", 32'(err), 1);
        check_quiet("err");
        rst_n = 0;
        #1;
        check("err_rst.state", 32'(state_o), 0);
        check("err_rst.err", 32'(err), 0);
        check("err_rst.retired", 32'(retired), 0);
        tick;
        rst_n = 1;

        // Reset arriving in the middle of S_MEM
        tick;
        ctrl_signal = C_LW; is_jalr = 0; is_mul = 0; mem_stall_D = 1;
        n = 0;
        while (state_o != 3'd3 && n < 16) begin
            tick;
            n++;
        end
        check("mid.reach_mem", 32'(state_o), 3);
        tick;
        check("mid.cen_d", 32'(mem_cen_D), 1);
        rst_n = 0;
        #1;
        check("mid.state", 32'(state_o), 0);
        check_quiet("mid");
        check("mid.retired", 32'(retired), 0);
        mem_stall_D = 0;
        tick;
        rst_n = 1;
        tick;

        // Counter wrap with a 4-bit counter
        exp_ret = 0;
        for (int i = 1; i <= 16; i++) begin
            run_instr(C_ADD, 0, 0, 0, 0, 0);
            if (i == 15) check("wrap.15", 32'(retired), 15);
            if (i == 16) check("wrap.0", 32'(retired), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
